round_key_store: RTL



---
 rtl/round_key_pkg.sv | 15 +
 rtl/round_key_ptr.sv | 39 +++
 rtl/round_key_store.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/round_key_pkg.sv
// Shared types and constants for the AES round-key store.
package round_key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        FULL
    } state_t;

    localparam int unsigned AES128_KEYS    = 10;
    localparam int unsigned AES192_KEYS    = 12;
    localparam int unsigned AES256_KEYS    = 14;
    localparam int unsigned DEFAULT_WORD_W = 32;

endpackage

// File: rtl/round_key_ptr.sv
// Stream write pointer: walks (key, word) from (1, 0) to (NUM_KEYS, last) and parks there.
module round_key_ptr #(
    parameter int unsigned NUM_KEYS      = 10,
    parameter int unsigned WORDS_PER_KEY = 4,
    parameter int unsigned IDX_W         = $clog2(NUM_KEYS + 1),
    parameter int unsigned BLK_W         = (WORDS_PER_KEY > 1) ? $clog2(WORDS_PER_KEY) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [IDX_W-1:0] ptr_key,
    output logic [BLK_W-1:0] ptr_blk,
    output logic             last
);

    logic blk_wrap;

    assign blk_wrap = (ptr_blk == BLK_W'(WORDS_PER_KEY - 1));
    assign last     = blk_wrap && (ptr_key == IDX_W'(NUM_KEYS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_key <= IDX_W'(1);
            ptr_blk <= '0;
        end else if (clear) begin
            ptr_key <= IDX_W'(1);
            ptr_blk <= '0;
        end else if (inc && !last) begin
            if (blk_wrap) begin
                ptr_blk <= '0;
                ptr_key <= ptr_key + IDX_W'(1);
            end else begin
                ptr_blk <= ptr_blk + BLK_W'(1);
            end
        end
    end

endmodule

// File: rtl/round_key_store.sv
// AES round-key register file: stream or addressed word writes, per-key load masks,
// registered read port and a flat parallel bus of all keys (key 1 most significant).
module round_key_store
    import round_key_pkg::*;
#(
    parameter int unsigned NUM_KEYS      = AES128_KEYS,
    parameter int unsigned WORD_W        = DEFAULT_WORD_W,
    parameter int unsigned WORDS_PER_KEY = 4,
    localparam int unsigned KEY_W        = WORD_W * WORDS_PER_KEY,
    localparam int unsigned IDX_W        = $clog2(NUM_KEYS + 1),
    localparam int unsigned BLK_W        = (WORDS_PER_KEY > 1) ? $clog2(WORDS_PER_KEY) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic                      wr_mode,
    input  logic [IDX_W-1:0]          wr_index,
    input  logic [BLK_W-1:0]          wr_blk,
    input  logic [WORD_W-1:0]         wr_word,
    output logic                      wr_err,
    input  logic                      rd_en,
    input  logic [IDX_W-1:0]          rd_index,
    output logic                      rd_valid,
    output logic [KEY_W-1:0]          rd_key,
    output logic                      rd_key_ok,
    output logic [NUM_KEYS-1:0]       key_valid,
    output logic                      all_loaded,
    output logic [NUM_KEYS*KEY_W-1:0] keys_flat
);

    state_t                   state_q, state_d;
    logic [KEY_W-1:0]         key_q  [NUM_KEYS];
    logic [WORDS_PER_KEY-1:0] mask_q [NUM_KEYS];
    logic [WORDS_PER_KEY-1:0] mask_d [NUM_KEYS];

    logic [IDX_W-1:0] ptr_key;
    logic [BLK_W-1:0] ptr_blk;
    logic             ptr_last;

    logic             accept, legal, do_write, all_loaded_d, stream_done;
    logic [IDX_W-1:0] tgt_key;
    logic [BLK_W-1:0] tgt_blk;

    assign wr_ready    = !reset && !clear && (wr_mode || state_q != FULL);
    assign accept      = wr_valid && wr_ready;
    assign do_write    = accept && legal;
    assign stream_done = accept && !wr_mode && ptr_last;

    // tgt_key is zero-based so it can index the storage arrays directly.
    always_comb begin
        if (wr_mode) begin
            legal   = (wr_index != '0) && (int'(wr_index) <= int'(NUM_KEYS))
                      && (int'(wr_blk) < int'(WORDS_PER_KEY));
            tgt_key = wr_index - IDX_W'(1);
            tgt_blk = wr_blk;
        end else begin
            legal   = 1'b1;
            tgt_key = ptr_key - IDX_W'(1);
            tgt_blk = ptr_blk;
        end
    end

    round_key_ptr #(
        .NUM_KEYS      (NUM_KEYS),
        .WORDS_PER_KEY (WORDS_PER_KEY),
        .IDX_W         (IDX_W),
        .BLK_W         (BLK_W)
    ) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .inc     (accept && !wr_mode),
        .ptr_key (ptr_key),
        .ptr_blk (ptr_blk),
        .last    (ptr_last)
    );

    // Next masks are computed up front so FULL is entered on the completing write itself.
    always_comb begin
        all_loaded_d = 1'b1;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            mask_d[i] = clear ? '0 : mask_q[i];
            for (int unsigned w = 0; w < WORDS_PER_KEY; w++) begin
                if (!clear && do_write && tgt_key == IDX_W'(i) && tgt_blk == BLK_W'(w))
                    mask_d[i][w] = 1'b1;
            end
            all_loaded_d = all_loaded_d && (&mask_d[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = (all_loaded_d || stream_done) ? FULL : LOADING;
                LOADING: if (all_loaded_d || stream_done) state_d = FULL;
                FULL:    state_d = FULL;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wr_err  <= 1'b0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) mask_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wr_err  <= accept && wr_mode && !legal;
            for (int unsigned i = 0; i < NUM_KEYS; i++) mask_q[i] <= mask_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) key_q[i] <= '0;
        end else if (do_write) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                for (int unsigned w = 0; w < WORDS_PER_KEY; w++) begin
                    if (tgt_key == IDX_W'(i) && tgt_blk == BLK_W'(w))
                        key_q[i][(WORDS_PER_KEY-1-w)*WORD_W +: WORD_W] <= wr_word;
                end
            end
        end
    end

    // Read samples pre-write storage and masks, giving read-before-write on collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_key    <= '0;
            rd_key_ok <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_key    <= '0;
                rd_key_ok <= 1'b0;
                for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                    if (rd_index == IDX_W'(i + 1)) begin
                        rd_key    <= key_q[i];
                        rd_key_ok <= &mask_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        keys_flat = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            keys_flat[(NUM_KEYS-1-i)*KEY_W +: KEY_W] = key_q[i];
            key_valid[i] = &mask_q[i];
        end
    end

    assign all_loaded = &key_valid;

endmodule
